sram_port_arb: RTL and testbench
================================

SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 SHALL have parameter AW, default 13, meaning SRAM word-address width.
REQ-002 SHALL have parameter DW, default 32, meaning SRAM data width.
REQ-003 SHALL have parameter STARVE_MAX, default 16, meaning engine-wait cycles that raise starve_flag.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 host_wr_en / host_wr_addr / host_wr_data  in  1/AW/DW  single-cycle host write pulse from ICB register slave.
REQ-007 host_rd_en / host_rd_addr  in  1/AW  single-cycle host read pulse.
REQ-008 host_rd_data  out  DW  host read data, valid the cycle after host_rd_en.
REQ-009 eng_req / eng_we / eng_addr / eng_wdata  in  1/1/AW/DW  accelerator engine request, held until granted.
REQ-010 eng_gnt  out  1  engine request accepted this cycle.
REQ-011 eng_rvalid / eng_rdata  out  1/DW  engine read return.
REQ-012 mem_en / mem_we / mem_addr / mem_wdata  out  1/1/AW/DW  single-port SRAM command.
REQ-013 mem_rdata  in  DW  SRAM read data, 1-cycle latency after mem_en & !mem_we.
REQ-014 host_err  out  1  pulse: host wr and rd in same cycle.
REQ-015 starve_flag  out  1  engine waited >= STARVE_MAX consecutive cycles.
REQ-016 conflict_cnt  out  16  saturating count of cycles engine was blocked by host.

Function
REQ-017 Host SHALL have absolute priority; host access is never stalled, delayed or dropped.
REQ-018 host_act = host_wr_en | host_rd_en; when host_act, mem_* SHALL carry host command in same cycle (combinational).
REQ-019 host_wr_en & host_rd_en together: write SHALL be performed, read suppressed, host_err=1 that cycle, host_rd_data next cycle = 0.
REQ-020 eng_gnt SHALL = eng_req & !host_act, combinational; when granted, mem_* carry engine command.
REQ-021 No request: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-022 Registered rd_owner (NONE/HOST/ENG) SHALL record owner of each issued SRAM read, updated every cycle.
REQ-023 rd_owner==HOST: host_rd_data SHALL = mem_rdata; otherwise host_rd_data = 0.
REQ-024 rd_owner==ENG: eng_rvalid=1, eng_rdata=mem_rdata; otherwise eng_rvalid=0, eng_rdata=0.
REQ-025 Granted engine writes SHALL produce no eng_rvalid.
REQ-026 wait_cnt SHALL increment each cycle eng_req & !eng_gnt, saturate at STARVE_MAX, clear on eng_gnt or !eng_req.
REQ-027 starve_flag SHALL be registered, = (wait_cnt == STARVE_MAX); clears cycle after wait_cnt clears.
REQ-028 conflict_cnt SHALL increment each cycle eng_req & host_act, saturate at 16'hFFFF, never wrap.
REQ-029 Back-to-back reads from alternating owners SHALL each return data to correct owner, one per cycle, no bubble.
REQ-030 Address/data widths SHALL pass unmodified; no address translation in this block.

Reset
REQ-031 rst_n low SHALL asynchronously clear rd_owner=NONE, wait_cnt=0, starve_flag=0, conflict_cnt=0.
REQ-032 During reset all outputs SHALL be 0 regardless of inputs; reads issued before reset return nothing after.
REQ-033 First access SHALL be accepted the first clk edge after rst_n deasserts.

Verification
REQ-034 Host write addr 5 data 32'hA5A5_0001, then host read addr 5 -> host_rd_data=32'hA5A5_0001 one cycle after read.
REQ-035 Engine write addr 0x10 = 32'h1234 alone -> eng_gnt=1 same cycle; engine read 0x10 -> eng_rvalid=1, eng_rdata=32'h1234 next cycle.
REQ-036 eng_req held, host reads 3 consecutive cycles -> eng_gnt=0 for 3 cycles, conflict_cnt=3, grant on 4th cycle.
REQ-037 Host read addr A then engine read addr B next cycle -> host_rd_data=mem[A] at t+1, eng_rvalid with mem[B] at t+2, host_rd_data=0 at t+2.
REQ-038 host_wr_en & host_rd_en same cycle -> write done, host_err=1 pulse, host_rd_data=0 next cycle.
REQ-039 Host active 20 cycles with eng_req held -> starve_flag=1 from cycle 17; rst_n pulse mid-run -> counters and starve_flag 0 immediately.

Source files
------------

// File: rtl/sram_port_arb_if.sv
// Bus bundle between the ICB host slave, the accelerator engine and the
// single-port SRAM macro. The arbiter takes the slave view; the agents and
// the memory that surround it take the master view.
interface sram_port_arb_if #(
    parameter int AW = 13,
    parameter int DW = 32
) ();
    logic          host_wr_en;
    logic [AW-1:0] host_wr_addr;
    logic [DW-1:0] host_wr_data;
    logic          host_rd_en;
    logic [AW-1:0] host_rd_addr;
    logic [DW-1:0] host_rd_data;

    logic          eng_req;
    logic          eng_we;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_wdata;
    logic          eng_gnt;
    logic          eng_rvalid;
    logic [DW-1:0] eng_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  host_wr_en, host_wr_addr, host_wr_data, host_rd_en, host_rd_addr,
        output host_rd_data,
        input  eng_req, eng_we, eng_addr, eng_wdata,
        output eng_gnt, eng_rvalid, eng_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output host_wr_en, host_wr_addr, host_wr_data, host_rd_en, host_rd_addr,
        input  host_rd_data,
        output eng_req, eng_we, eng_addr, eng_wdata,
        input  eng_gnt, eng_rvalid, eng_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/sram_port_arb.sv
// Single-port SRAM arbiter: the host always wins the port in the cycle it
// asks; the engine gets whatever cycles the host leaves free. Read data is
// steered back to whoever issued the read one cycle earlier, tracked by a
// small owner register. Starvation and conflict statistics are kept for
// software visibility.
module sram_port_arb #(
    parameter int AW         = 13,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_port_arb_if.slave bus,
    output logic          host_err,
    output logic          starve_flag,
    output logic [15:0]   conflict_cnt
);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_HOST = 2'd1;
    localparam logic [1:0] OWN_ENG  = 2'd2;

    localparam int             WCW      = $clog2(STARVE_MAX + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(STARVE_MAX);

    logic          host_act_s;
    logic          gnt_s;
    logic          mem_en_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [DW-1:0] mem_wdata_s;
    logic [1:0]    owner_nxt_s;
    logic [DW-1:0] host_rd_data_s;
    logic          eng_rvalid_s;
    logic [DW-1:0] eng_rdata_s;

    logic [1:0]     rd_owner_r;
    logic [WCW-1:0] wait_cnt_r;
    logic           starve_r;
    logic [15:0]    conflict_r;

    // Port arbitration: host first, engine only in host-free cycles. Outputs
    // are forced low while reset is asserted so nothing leaks to the macro.
    always_comb begin
        host_act_s  = bus.host_wr_en | bus.host_rd_en;
        gnt_s       = 1'b0;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {AW{1'b0}};
        mem_wdata_s = {DW{1'b0}};
        owner_nxt_s = OWN_NONE;
        if (!rst_n) begin
            gnt_s = 1'b0;
        end else if (bus.host_wr_en) begin
            // A simultaneous host read is dropped; the write wins.
            mem_en_s    = 1'b1;
            mem_we_s    = 1'b1;
            mem_addr_s  = bus.host_wr_addr;
            mem_wdata_s = bus.host_wr_data;
        end else if (bus.host_rd_en) begin
            mem_en_s    = 1'b1;
            mem_addr_s  = bus.host_rd_addr;
            owner_nxt_s = OWN_HOST;
        end else if (bus.eng_req) begin
            gnt_s       = 1'b1;
            mem_en_s    = 1'b1;
            mem_we_s    = bus.eng_we;
            mem_addr_s  = bus.eng_addr;
            mem_wdata_s = bus.eng_wdata;
            owner_nxt_s = bus.eng_we ? OWN_NONE : OWN_ENG;
        end else begin
            gnt_s = 1'b0;
        end
    end

    // Read return steering based on who issued last cycle's read.
    always_comb begin
        host_rd_data_s = {DW{1'b0}};
        eng_rvalid_s   = 1'b0;
        eng_rdata_s    = {DW{1'b0}};
        case (rd_owner_r)
            OWN_HOST: host_rd_data_s = bus.mem_rdata;
            OWN_ENG: begin
                eng_rvalid_s = 1'b1;
                eng_rdata_s  = bus.mem_rdata;
            end
            default: host_rd_data_s = {DW{1'b0}};
        endcase
    end

    // Read-owner tracking, one entry for the single outstanding SRAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner_r <= OWN_NONE;
        end else begin
            rd_owner_r <= owner_nxt_s;
        end
    end

    // Engine wait counter (saturating) and the starvation flag derived from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {WCW{1'b0}};
            starve_r   <= 1'b0;
        end else begin
            starve_r <= (wait_cnt_r == WAIT_MAX);
            if (bus.eng_req && !gnt_s) begin
                if (wait_cnt_r != WAIT_MAX) begin
                    wait_cnt_r <= wait_cnt_r + WCW'(1);
                end else begin
                    wait_cnt_r <= wait_cnt_r;
                end
            end else begin
                wait_cnt_r <= {WCW{1'b0}};
            end
        end
    end

    // Saturating count of cycles the engine lost the port to the host.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_r <= 16'd0;
        end else if (bus.eng_req && host_act_s && (conflict_r != 16'hFFFF)) begin
            conflict_r <= conflict_r + 16'd1;
        end else begin
            conflict_r <= conflict_r;
        end
    end

    assign bus.eng_gnt      = gnt_s;
    assign bus.mem_en       = mem_en_s;
    assign bus.mem_we       = mem_we_s;
    assign bus.mem_addr     = mem_addr_s;
    assign bus.mem_wdata    = mem_wdata_s;
    assign bus.host_rd_data = host_rd_data_s;
    assign bus.eng_rvalid   = eng_rvalid_s;
    assign bus.eng_rdata    = eng_rdata_s;
    assign host_err         = rst_n & bus.host_wr_en & bus.host_rd_en;
    assign starve_flag      = starve_r;
    assign conflict_cnt     = conflict_r;
endmodule

// File: tb/tb_sram_port_arb.sv
// Bench for sram_port_arb: a behavioural SRAM on the bus plus a reference
// model that predicts every output from the arbitration rules, driven by a
// directed sequence followed by randomized traffic.
module tb_sram_port_arb;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int SM = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_err;
    logic        starve_flag;
    logic [15:0] conflict_cnt;
    int          checks = 0;
    int          failures = 0;

    sram_port_arb_if #(.AW(AW), .DW(DW)) bus ();

    sram_port_arb #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .host_err(host_err), .starve_flag(starve_flag), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro with one-cycle read latency.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
        else if (bus.mem_en) bus.mem_rdata <= sram[bus.mem_addr];
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            m_ph;      // host read data due this cycle
    logic [DW-1:0] m_phd;
    bit            m_pe;      // engine read data due this cycle
    logic [DW-1:0] m_ped;
    int            m_wait;
    bit            m_starve;
    int            m_conf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_pe = 0; m_phd = '0; m_ped = '0;
        m_wait = 0; m_starve = 0; m_conf = 0;
    endtask

    task automatic set_idle();
        bus.host_wr_en = 0; bus.host_rd_en = 0; bus.host_wr_addr = '0;
        bus.host_wr_data = '0; bus.host_rd_addr = '0;
        bus.eng_req = 0; bus.eng_we = 0; bus.eng_addr = '0; bus.eng_wdata = '0;
    endtask

    // Compare every output with the model's prediction for the current cycle.
    task automatic check_model();
        bit hact, gnt, we, en;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        hact = bus.host_wr_en | bus.host_rd_en;
        gnt  = bus.eng_req & !hact;
        en   = hact | gnt;
        we   = bus.host_wr_en | (gnt & bus.eng_we);
        addr = bus.host_wr_en ? bus.host_wr_addr : bus.host_rd_en ? bus.host_rd_addr :
               gnt ? bus.eng_addr : '0;
        wd   = bus.host_wr_en ? bus.host_wr_data : bus.eng_wdata;
        chk("eng_gnt", {31'd0, bus.eng_gnt}, {31'd0, gnt});
        chk("mem_en", {31'd0, bus.mem_en}, {31'd0, en});
        chk("mem_we", {31'd0, bus.mem_we}, {31'd0, we});
        chk("mem_addr", {19'd0, bus.mem_addr}, {19'd0, addr});
        if (we) chk("mem_wdata", bus.mem_wdata, wd);
        chk("host_err", {31'd0, host_err}, {31'd0, bus.host_wr_en & bus.host_rd_en});
        chk("host_rd_data", bus.host_rd_data, m_ph ? m_phd : 32'd0);
        chk("eng_rvalid", {31'd0, bus.eng_rvalid}, {31'd0, m_pe});
        chk("eng_rdata", bus.eng_rdata, m_pe ? m_ped : 32'd0);
        chk("starve_flag", {31'd0, starve_flag}, {31'd0, m_starve});
        chk("conflict_cnt", {16'd0, conflict_cnt}, m_conf[31:0]);
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_step();
        bit hact, gnt;
        hact = bus.host_wr_en | bus.host_rd_en;
        gnt  = bus.eng_req & !hact;
        m_starve = (m_wait == SM);
        m_wait   = (bus.eng_req && !gnt) ? ((m_wait < SM) ? m_wait + 1 : SM) : 0;
        if (bus.eng_req && hact && m_conf < 65535) m_conf = m_conf + 1;
        m_ph  = bus.host_rd_en & !bus.host_wr_en;
        m_phd = ref_mem[bus.host_rd_addr];
        m_pe  = gnt & !bus.eng_we;
        m_ped = ref_mem[bus.eng_addr];
        if (bus.host_wr_en) ref_mem[bus.host_wr_addr] = bus.host_wr_data;
        else if (gnt && bus.eng_we) ref_mem[bus.eng_addr] = bus.eng_wdata;
    endtask

    // One full cycle: inputs were driven at edge+1; check, clock, update.
    task automatic cyc();
        #2;
        check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_idle(); bus.host_wr_en = 1; bus.host_wr_addr = a; bus.host_wr_data = d;
    endtask

    task automatic host_rd(input logic [AW-1:0] a);
        set_idle(); bus.host_rd_en = 1; bus.host_rd_addr = a;
    endtask

    task automatic eng(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_idle(); bus.eng_req = 1; bus.eng_we = w; bus.eng_addr = a; bus.eng_wdata = d;
    endtask

    initial begin
        logic [DW-1:0] a_val;
        logic [DW-1:0] b_val;
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i] = '0;
            ref_mem[i] = '0;
        end
        bus.mem_rdata = '0;
        model_reset();

        // Reset: outputs quiet despite active requests
        set_idle();
        bus.host_rd_en = 1; bus.host_wr_en = 1; bus.eng_req = 1; bus.host_rd_addr = 13'd3;
        #3;
        chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("rst_gnt", {31'd0, bus.eng_gnt}, 32'd0);
        chk("rst_err", {31'd0, host_err}, 32'd0);
        chk("rst_conf", {16'd0, conflict_cnt}, 32'd0);
        set_idle();
        @(posedge clk); #1;
        rst_n = 1;

        // Host write then read-back, accepted right after reset release
        host_wr(13'd5, 32'hA5A5_0001); cyc();
        host_rd(13'd5); cyc();
        set_idle(); #1;
        chk("host_readback", bus.host_rd_data, 32'hA5A5_0001);
        cyc();

        // Engine write alone granted same cycle, read returns next cycle
        eng(1'b1, 13'h10, 32'h1234); #1;
        chk("eng_wr_gnt", {31'd0, bus.eng_gnt}, 32'd1);
        cyc();
        eng(1'b0, 13'h10, 32'h0); cyc();
        set_idle(); #1;
        chk("eng_rvalid", {31'd0, bus.eng_rvalid}, 32'd1);
        chk("eng_rdata", bus.eng_rdata, 32'h1234);
        cyc();

        // Engine blocked by 3 host reads, granted on the 4th cycle
        for (int i = 0; i < 3; i++) begin
            host_rd(13'd5); bus.eng_req = 1; bus.eng_addr = 13'h10; cyc();
        end
        eng(1'b0, 13'h10, 32'h0); #1;
        chk("blocked_gnt4", {31'd0, bus.eng_gnt}, 32'd1);
        chk("blocked_conf", {16'd0, conflict_cnt}, 32'd3);
        cyc();
        set_idle(); cyc();

        // Alternating owners back to back, no bubble
        a_val = 32'hCAFE_0020; b_val = 32'hBEEF_0021;
        host_wr(13'h20, a_val); cyc();
        eng(1'b1, 13'h21, b_val); cyc();
        host_rd(13'h20); cyc();
        eng(1'b0, 13'h21, 32'h0); #1;
        chk("alt_host_t1", bus.host_rd_data, a_val);
        cyc();
        set_idle(); #1;
        chk("alt_eng_valid_t2", {31'd0, bus.eng_rvalid}, 32'd1);
        chk("alt_eng_data_t2", bus.eng_rdata, b_val);
        chk("alt_host_zero_t2", bus.host_rd_data, 32'd0);
        cyc();

        // Simultaneous host write and read
        host_wr(13'h30, 32'h0BAD_F00D); bus.host_rd_en = 1; bus.host_rd_addr = 13'h5; #1;
        chk("both_err", {31'd0, host_err}, 32'd1);
        cyc();
        host_rd(13'h30); #1;
        chk("both_rd_zero", bus.host_rd_data, 32'd0);
        cyc();
        set_idle(); #1;
        chk("both_wr_done", bus.host_rd_data, 32'h0BAD_F00D);
        cyc();

        // Starvation: host busy 20 cycles while engine waits
        for (int i = 1; i <= 20; i++) begin
            host_rd(13'(i)); bus.eng_req = 1; bus.eng_addr = 13'h10;
            cyc();
            if (i == 16) chk("starve_c16", {31'd0, starve_flag}, 32'd0);
            if (i == 17) chk("starve_c17", {31'd0, starve_flag}, 32'd1);
        end
        // Reset pulse mid-cycle while both are active
        host_rd(13'h20); bus.eng_req = 1; #1;
        rst_n = 0; #1;
        chk("midrst_starve", {31'd0, starve_flag}, 32'd0);
        chk("midrst_conf", {16'd0, conflict_cnt}, 32'd0);
        chk("midrst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("midrst_rd_data", bus.host_rd_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        set_idle(); cyc();

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            bit keep, busy;
            logic [31:0] r;
            keep = bus.eng_req && (bus.host_wr_en || bus.host_rd_en);
            busy = ((i / 60) % 2) == 1;
            r = $urandom;
            bus.host_wr_en = 0; bus.host_rd_en = 0;
            if (busy ? (r[3:0] != 4'd0) : (r[1:0] == 2'd0)) begin
                bus.host_wr_en = r[4];
                bus.host_rd_en = !r[4] || (r[9:6] == 4'd0);
            end
            bus.host_wr_addr = 13'($urandom_range(0, 15));
            bus.host_rd_addr = 13'($urandom_range(0, 15));
            bus.host_wr_data = $urandom;
            if (!keep) begin
                bus.eng_req   = r[5] | r[10];
                bus.eng_we    = r[11];
                bus.eng_addr  = 13'($urandom_range(0, 15));
                bus.eng_wdata = $urandom;
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
